conv_layer_scheduler: RTL and testbench

Sequencer for the shared 3x3 convolution MAC engine. It watches the master FSM state code and, for each of the six conv states, configures the layer (feature-map size, output-channel count, layer id). It then issues one output-pixel request per position in raster order and pulses `Conv_done` back to the master FSM when the layer is complete. It sits between the master FSM and the MAC engine. It is the only source of `Conv_done`.

---
 rtl/conv_layer_scheduler_if.sv | 49 ++++
 rtl/conv_layer_scheduler.sv | 236 +++++++++++++++++++++++
 tb/tb_conv_layer_scheduler.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_layer_scheduler_if.sv
// Master-FSM / MAC-engine facing bundle of the conv layer scheduler.
// The master modport is the scheduler side; slave is the engine/master-FSM side.
interface conv_layer_scheduler_if #(
    parameter int unsigned STATE_DATAWIDTH = 4,
    parameter int unsigned ADDR_W          = 16
);
    logic [STATE_DATAWIDTH-1:0] state;
    logic                       mac_req;
    logic                       mac_ack;
    logic [2:0]                 layer_id;
    logic [4:0]                 oc;
    logic [6:0]                 row;
    logic [6:0]                 col;
    logic [ADDR_W-1:0]          out_addr;
    logic                       busy;
    logic                       Conv_done;
    logic [31:0]                perf_cycles;
    logic [31:0]                perf_stall;

    modport master (
        input  state,
        input  mac_ack,
        output mac_req,
        output layer_id,
        output oc,
        output row,
        output col,
        output out_addr,
        output busy,
        output Conv_done,
        output perf_cycles,
        output perf_stall
    );

    modport slave (
        output state,
        output mac_ack,
        input  mac_req,
        input  layer_id,
        input  oc,
        input  row,
        input  col,
        input  out_addr,
        input  busy,
        input  Conv_done,
        input  perf_cycles,
        input  perf_stall
    );
endinterface

// File: rtl/conv_layer_scheduler.sv
// Sequences the shared 3x3 MAC engine through the six conv layers in raster order.
// Optional performance counters are enabled with the SCHED_PERF_EN macro.
module conv_layer_scheduler #(
    parameter int unsigned STATE_DATAWIDTH = 4,
    parameter int unsigned ADDR_W          = 16,
    parameter int unsigned IMG_SIZE        = 80,
    parameter int unsigned CH1             = 4,
    parameter int unsigned CH2             = 8,
    parameter int unsigned CH3             = 16,
    parameter int unsigned CONV1_1_STATE   = 2,
    parameter int unsigned CONV1_2_STATE   = 3,
    parameter int unsigned CONV2_1_STATE   = 5,
    parameter int unsigned CONV2_2_STATE   = 6,
    parameter int unsigned CONV3_1_STATE   = 8,
    parameter int unsigned CONV3_2_STATE   = 9
) (
    input  logic                   clk,
    input  logic                   reset,
    conv_layer_scheduler_if.master bus
);
    localparam int unsigned SW = STATE_DATAWIDTH;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;

    localparam logic [SW-1:0] C11 = SW'(CONV1_1_STATE);
    localparam logic [SW-1:0] C12 = SW'(CONV1_2_STATE);
    localparam logic [SW-1:0] C21 = SW'(CONV2_1_STATE);
    localparam logic [SW-1:0] C22 = SW'(CONV2_2_STATE);
    localparam logic [SW-1:0] C31 = SW'(CONV3_1_STATE);
    localparam logic [SW-1:0] C32 = SW'(CONV3_2_STATE);

    localparam logic [6:0] SIDE1 = 7'(IMG_SIZE);
    localparam logic [6:0] SIDE2 = 7'(IMG_SIZE / 2);
    localparam logic [6:0] SIDE3 = 7'(IMG_SIZE / 4);
    localparam logic [4:0] LIM1  = 5'(CH1);
    localparam logic [4:0] LIM2  = 5'(CH2);
    localparam logic [4:0] LIM3  = 5'(CH3);

    logic [2:0]        fsm_q,      fsm_d;
    logic [SW-1:0]     cur_state_q, cur_state_d;
    logic [2:0]        layer_id_q, layer_id_d;
    logic [6:0]        side_q,     side_d;
    logic [4:0]        limit_q,    limit_d;
    logic [4:0]        oc_q,       oc_d;
    logic [6:0]        row_q,      row_d;
    logic [6:0]        col_q,      col_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic              mac_req_q,  mac_req_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;

    logic conv_hit_c;
    logic same_state_c;
    logic last_pix_c;
    logic col_wrap_c;
    logic row_wrap_c;

    assign conv_hit_c = (bus.state == C11) || (bus.state == C12) ||
                        (bus.state == C21) || (bus.state == C22) ||
                        (bus.state == C31) || (bus.state == C32);
    assign same_state_c = (bus.state == cur_state_q);
    assign col_wrap_c   = (col_q == 7'(side_q - 7'd1));
    assign row_wrap_c   = (row_q == 7'(side_q - 7'd1));
    assign last_pix_c   = col_wrap_c && row_wrap_c && (oc_q == 5'(limit_q - 5'd1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_q       <= ST_IDLE;
            cur_state_q <= '0;
            layer_id_q  <= '0;
            side_q      <= '0;
            limit_q     <= '0;
            oc_q        <= '0;
            row_q       <= '0;
            col_q       <= '0;
            out_addr_q  <= '0;
            mac_req_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            cur_state_q <= cur_state_d;
            layer_id_q  <= layer_id_d;
            side_q      <= side_d;
            limit_q     <= limit_d;
            oc_q        <= oc_d;
            row_q       <= row_d;
            col_q       <= col_d;
            out_addr_q  <= out_addr_d;
            mac_req_q   <= mac_req_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state and registered-output logic; pulse outputs default low every cycle.
    always_comb begin
        fsm_d       = fsm_q;
        cur_state_d = cur_state_q;
        layer_id_d  = layer_id_q;
        side_d      = side_q;
        limit_d     = limit_q;
        oc_d        = oc_q;
        row_d       = row_q;
        col_d       = col_q;
        out_addr_d  = out_addr_q;
        mac_req_d   = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        case (fsm_q)
            ST_IDLE: begin
                if (conv_hit_c) begin
                    cur_state_d = bus.state;
                    busy_d      = 1'b1;
                    fsm_d       = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!same_state_c) begin
                    fsm_d = ST_IDLE;
                end else begin
                    case (cur_state_q)
                        C11:     begin layer_id_d = 3'd0; side_d = SIDE1; limit_d = LIM1; end
                        C12:     begin layer_id_d = 3'd1; side_d = SIDE1; limit_d = LIM1; end
                        C21:     begin layer_id_d = 3'd2; side_d = SIDE2; limit_d = LIM2; end
                        C22:     begin layer_id_d = 3'd3; side_d = SIDE2; limit_d = LIM2; end
                        C31:     begin layer_id_d = 3'd4; side_d = SIDE3; limit_d = LIM3; end
                        default: begin layer_id_d = 3'd5; side_d = SIDE3; limit_d = LIM3; end
                    endcase
                    oc_d       = '0;
                    row_d      = '0;
                    col_d      = '0;
                    out_addr_d = '0;
                    mac_req_d  = 1'b1;
                    busy_d     = 1'b1;
                    fsm_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!same_state_c) begin
                    fsm_d = ST_IDLE;
                end else begin
                    busy_d    = 1'b1;
                    mac_req_d = 1'b1;
                    if (mac_req_q && bus.mac_ack) begin
                        if (last_pix_c) begin
                            // Counters keep the final pixel's position.
                            mac_req_d = 1'b0;
                            done_d    = 1'b1;
                            fsm_d     = ST_DONE;
                        end else begin
                            out_addr_d = out_addr_q + ADDR_W'(1);
                            if (col_wrap_c) begin
                                col_d = '0;
                                if (row_wrap_c) begin
                                    row_d = '0;
                                    oc_d  = oc_q + 5'd1;
                                end else begin
                                    row_d = row_q + 7'd1;
                                end
                            end else begin
                                col_d = col_q + 7'd1;
                            end
                        end
                    end
                end
            end
            ST_DONE: begin
                fsm_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (!same_state_c) begin
                    fsm_d = ST_IDLE;
                end
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
    end

    assign bus.mac_req   = mac_req_q;
    assign bus.layer_id  = layer_id_q;
    assign bus.oc        = oc_q;
    assign bus.row       = row_q;
    assign bus.col       = col_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.busy      = busy_q;
    assign bus.Conv_done = done_q;

`ifdef SCHED_PERF_EN
    localparam logic [31:0] PERF_MAX = '1;

    logic [31:0] perf_cycles_q, perf_cycles_d;
    logic [31:0] perf_stall_q,  perf_stall_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_cycles_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            perf_cycles_q <= perf_cycles_d;
            perf_stall_q  <= perf_stall_d;
        end
    end

    // The LOAD cycle itself is busy, so the cycle count restarts at one.
    always_comb begin
        perf_cycles_d = perf_cycles_q;
        perf_stall_d  = perf_stall_q;
        if (fsm_q == ST_LOAD) begin
            perf_cycles_d = 32'd1;
            perf_stall_d  = '0;
        end else begin
            if (busy_q && (perf_cycles_q != PERF_MAX)) begin
                perf_cycles_d = perf_cycles_q + 32'd1;
            end
            if (mac_req_q && !bus.mac_ack && (perf_stall_q != PERF_MAX)) begin
                perf_stall_d = perf_stall_q + 32'd1;
            end
        end
    end

    assign bus.perf_cycles = perf_cycles_q;
    assign bus.perf_stall  = perf_stall_q;
`else
    assign bus.perf_cycles = '0;
    assign bus.perf_stall  = '0;
`endif

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// Scoreboard bench for conv_layer_scheduler: raster-order reference beats are queued
// at layer start and a negedge monitor compares them against every request cycle.
module tb_conv_layer_scheduler;
    localparam int unsigned SDW = 4;
    localparam int unsigned AW  = 16;
    localparam int unsigned IMG = 80;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    conv_layer_scheduler_if #(.STATE_DATAWIDTH(SDW), .ADDR_W(AW)) bus ();

    conv_layer_scheduler #(.STATE_DATAWIDTH(SDW), .ADDR_W(AW), .IMG_SIZE(IMG)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int lid;
        int oc;
        int row;
        int col;
        int addr;
        bit last;
    } beat_t;

    beat_t exp_q[$];
    bit    done_exp = 1'b0;
    int    checks   = 0;
    int    errors   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Layer geometry straight from the layer table.
    task automatic layer_cfg(input int code, output int lid, output int s, output int lim);
        case (code)
            2:       begin lid = 0; s = IMG;     lim = 4;  end
            3:       begin lid = 1; s = IMG;     lim = 4;  end
            5:       begin lid = 2; s = IMG / 2; lim = 8;  end
            6:       begin lid = 3; s = IMG / 2; lim = 8;  end
            8:       begin lid = 4; s = IMG / 4; lim = 16; end
            default: begin lid = 5; s = IMG / 4; lim = 16; end
        endcase
    endtask

    task automatic push_layer(input int code, output int n);
        int lid, s, lim;
        beat_t b;
        layer_cfg(code, lid, s, lim);
        n = lim * s * s;
        exp_q.delete();
        for (int o = 0; o < lim; o++)
            for (int r = 0; r < s; r++)
                for (int c = 0; c < s; c++) begin
                    b.lid  = lid;
                    b.oc   = o;
                    b.row  = r;
                    b.col  = c;
                    b.addr = (o * s + r) * s + c;
                    b.last = (o == lim - 1) && (r == s - 1) && (c == s - 1);
                    exp_q.push_back(b);
                end
    endtask

    // Monitor: every request cycle must present the next expected beat; done follows the last one.
    always @(negedge clk) begin
        bit nd;
        nd = 1'b0;
        if (reset !== 1'b1) begin
            done_exp = 1'b0;
        end else begin
            if (bus.Conv_done !== 1'b0 || done_exp)
                check("conv_done", 64'(bus.Conv_done), 64'(done_exp));
            if (bus.mac_req === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("mac_req_unexpected", 64'(bus.mac_req), 64'd0);
                end else begin
                    check("layer_id", 64'(bus.layer_id), 64'(exp_q[0].lid));
                    check("oc",       64'(bus.oc),       64'(exp_q[0].oc));
                    check("row",      64'(bus.row),      64'(exp_q[0].row));
                    check("col",      64'(bus.col),      64'(exp_q[0].col));
                    check("out_addr", 64'(bus.out_addr), 64'(exp_q[0].addr));
                    if (bus.mac_ack === 1'b1) begin
                        nd = exp_q[0].last;
                        void'(exp_q.pop_front());
                    end
                end
            end
            done_exp = nd;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_mac_req"},  64'(bus.mac_req),     64'd0);
        check({tag, "_busy"},     64'(bus.busy),        64'd0);
        check({tag, "_done"},     64'(bus.Conv_done),   64'd0);
        check({tag, "_layer_id"}, 64'(bus.layer_id),    64'd0);
        check({tag, "_oc"},       64'(bus.oc),          64'd0);
        check({tag, "_row"},      64'(bus.row),         64'd0);
        check({tag, "_col"},      64'(bus.col),         64'd0);
        check({tag, "_out_addr"}, 64'(bus.out_addr),    64'd0);
        check({tag, "_perf_cyc"}, 64'(bus.perf_cycles), 64'd0);
        check({tag, "_perf_stl"}, 64'(bus.perf_stall),  64'd0);
    endtask

    // mode 0: ack always high, 1: ack toggles starting high, 2: ack random (90% high)
    task automatic run_layer(input int code, input int mode);
        int n, hs, stall, cyc;
        bit ack, tog;
        push_layer(code, n);
        bus.mac_ack = 1'b0;
        bus.state   = SDW'(code);
        check("busy_cycle0", 64'(bus.busy), 64'd0);
        tick();
        check("busy_load", 64'(bus.busy), 64'd1);
        check("req_load",  64'(bus.mac_req), 64'd0);
        hs = 0; stall = 0; cyc = 1; tog = 1'b1;
        while (hs < n) begin
            tick();
            cyc++;
            check("req_issue", 64'(bus.mac_req), 64'd1);
            case (mode)
                0:       ack = 1'b1;
                1:       ack = tog;
                default: ack = ($urandom_range(0, 9) != 0);
            endcase
            tog = ~tog;
            bus.mac_ack = ack;
            if (ack) hs++;
            else     stall++;
        end
        tick();
        cyc++;
        bus.mac_ack = 1'b0;
        check("busy_done", 64'(bus.busy), 64'd1);
        check("req_done",  64'(bus.mac_req), 64'd0);
        tick();
        check("busy_hold",  64'(bus.busy), 64'd0);
        check("beats_left", 64'(exp_q.size()), 64'd0);
`ifdef SCHED_PERF_EN
        check("perf_cycles", 64'(bus.perf_cycles), 64'(cyc));
        check("perf_stall",  64'(bus.perf_stall),  64'(stall));
`else
        check("perf_cycles", 64'(bus.perf_cycles), 64'd0);
        check("perf_stall",  64'(bus.perf_stall),  64'd0);
`endif
    endtask

    task automatic gap();
        bus.state = '0;
        tick();
        tick();
    endtask

    initial begin
        int n;
        reset       = 1'b0;
        bus.state   = '0;
        bus.mac_ack = 1'b0;
        #12;
        check_zero("reset");
        @(negedge clk);
        reset = 1'b1;
        tick();

        run_layer(2, 0); gap();
        run_layer(9, 1); gap();
        run_layer(5, 2); gap();
        run_layer(8, 2); gap();

        // Staying in the same conv code must not relaunch the layer.
        run_layer(3, 0);
        repeat (100) begin
            tick();
            check("hold_req",  64'(bus.mac_req), 64'd0);
            check("hold_busy", 64'(bus.busy),    64'd0);
        end
        bus.state = SDW'(4);
        repeat (5) begin
            tick();
            check("pool_busy", 64'(bus.busy), 64'd0);
        end
        gap();

        // Abort mid-layer, then restart from address 0.
        push_layer(2, n);
        bus.state = SDW'(2);
        tick();
        repeat (50) begin
            tick();
            bus.mac_ack = 1'b1;
        end
        tick();
        bus.mac_ack = 1'b0;
        bus.state   = '0;
        tick();
        check("abort_req",  64'(bus.mac_req), 64'd0);
        check("abort_busy", 64'(bus.busy),    64'd0);
        exp_q.delete();
        repeat (5) tick();

        push_layer(2, n);
        bus.state = SDW'(2);
        tick();
        repeat (30) begin
            tick();
            bus.mac_ack = 1'b1;
        end
        tick();
        bus.mac_ack = 1'b0;
        check("restart_beats", 64'(exp_q.size()), 64'(n - 30));
        #2;
        reset = 1'b0;
        #1;
        check_zero("async_reset");
        exp_q.delete();
        bus.state = '0;
        @(negedge clk);
        reset = 1'b1;
        tick();
        tick();
        check("post_reset_req",  64'(bus.mac_req), 64'd0);
        check("post_reset_busy", 64'(bus.busy),    64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
